// File: rtl/tcdm_varlat_pkg.sv
// Shared helpers for the variable-latency TCDM crossbar (master-side decoder and bank-side stage).
package tcdm_varlat_pkg;

  // Slot after sel, wrapping to zero at num; drives both the arbiter pointer and FIFO pointers.
  function automatic logic [31:0] rr_next(input logic [31:0] sel, input logic [31:0] num);
    logic [31:0] nxt;
    if (sel >= (num - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = sel + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bank_arb_resp_demux_varlat_chk.sv
// Simulation-only protocol checks for the bank-side arbiter/response demux.
module bank_arb_resp_demux_varlat_chk #(
  parameter int NumIn          = 4,
  parameter int MaxOutstanding = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [NumIn-1:0] gnt_o,
  input logic [NumIn-1:0] vld_o,
  input logic             push_i,
  input logic             full_i
);

  a_params: assert property (@(posedge clk_i) (NumIn > 0) && (MaxOutstanding > 0))
    else $fatal(1, "bank_arb_resp_demux_varlat: NumIn and MaxOutstanding must be positive");

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o))
    else $error("gnt_o has more than one bit set");

  a_vld_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(vld_o))
    else $error("vld_o has more than one bit set");

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i))
    else $error("ID FIFO pushed while full");

endmodule

// File: rtl/varlat_id_fifo.sv
// In-order FIFO of granted master indices; depth need not be a power of two.
module varlat_id_fifo
  import tcdm_varlat_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 2,
  localparam int LogD = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [LogD-1:0]  r_wr_ptr;
  logic [LogD-1:0]  r_rd_ptr;
  logic [LogD:0]    r_cnt;
  logic [Width-1:0] r_mem [Depth];
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_cnt == (LogD + 1)'(Depth));
  assign empty_o = (r_cnt == {(LogD + 1){1'b0}});
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rd_ptr];

  // Pointer and occupancy update; simultaneous push/pop leaves the count untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= {LogD{1'b0}};
      r_rd_ptr <= {LogD{1'b0}};
      r_cnt    <= {(LogD + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= LogD'(rr_next(32'(r_wr_ptr), 32'(Depth)));
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= LogD'(rr_next(32'(r_rd_ptr), 32'(Depth)));
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (LogD + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (LogD + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bank_arb_resp_demux_varlat.sv
// Bank-side crossbar stage: round-robin arbitration onto one bank port and in-order
// routing of variable-latency responses back to the master that issued each request.
module bank_arb_resp_demux_varlat
  import tcdm_varlat_pkg::*;
#(
  parameter int NumIn          = 4,
  parameter int ReqDataWidth   = 32,
  parameter int RespDataWidth  = 32,
  parameter int MaxOutstanding = 4,
  parameter int LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [RespDataWidth-1:0]             rdata_o,
  output logic                                 req_o,
  output logic [ReqDataWidth-1:0]              data_o,
  input  logic                                 gnt_i,
  input  logic                                 vld_i,
  input  logic [RespDataWidth-1:0]             rdata_i,
  output logic                                 err_o
);

  logic [LogNumIn-1:0] r_rr;
  logic                r_err;
  logic [LogNumIn-1:0] w_sel;
  logic [LogNumIn-1:0] w_sel_lo;
  logic [LogNumIn-1:0] w_sel_hi;
  logic                w_hit_hi;
  logic                w_take;
  logic [LogNumIn-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_pop;

  // Rotating priority: lowest requester at or above r_rr wins, else lowest requester overall.
  always_comb begin
    w_sel_lo = {LogNumIn{1'b0}};
    w_sel_hi = {LogNumIn{1'b0}};
    w_hit_hi = 1'b0;
    w_take   = 1'b0;
    for (int k = NumIn - 1; k >= 0; k--) begin
      w_take   = req_i[k] && (LogNumIn'(k) >= r_rr);
      w_sel_lo = req_i[k] ? LogNumIn'(k) : w_sel_lo;
      w_sel_hi = w_take ? LogNumIn'(k) : w_sel_hi;
      w_hit_hi = w_take | w_hit_hi;
    end
    w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
  end

  // Bank request, per-master grant and response steering; all quiet while in reset.
  always_comb begin
    req_o = 1'b0;
    gnt_o = {NumIn{1'b0}};
    vld_o = {NumIn{1'b0}};
    if (rst_i) begin
      req_o = 1'b0;
    end else begin
      req_o = (|req_i) & ~w_full;
      for (int k = 0; k < NumIn; k++) begin
        gnt_o[k] = req_o & gnt_i & (w_sel == LogNumIn'(k));
        vld_o[k] = vld_i & ~w_empty & (w_head == LogNumIn'(k));
      end
    end
  end

  assign w_accept = req_o & gnt_i;
  assign w_pop    = vld_i & ~w_empty & ~rst_i;
  assign data_o   = data_i[w_sel];
  assign rdata_o  = rdata_i;
  assign err_o    = r_err;

  // Round-robin pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= {LogNumIn{1'b0}};
    end else if (w_accept) begin
      r_rr <= LogNumIn'(rr_next(32'(w_sel), 32'(NumIn)));
    end else begin
      r_rr <= r_rr;
    end
  end

  // Sticky flag for a bank response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (vld_i & w_empty) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  varlat_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (LogNumIn)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_accept),
    .data_i  (w_sel),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  bank_arb_resp_demux_varlat_chk #(
    .NumIn          (NumIn),
    .MaxOutstanding (MaxOutstanding)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .gnt_o  (gnt_o),
    .vld_o  (vld_o),
    .push_i (w_accept),
    .full_i (w_full)
  );

endmodule

// File: tb/tb_bank_arb_resp_demux_varlat.sv
// Directed bench: instance A (MaxOutstanding=4) for arbitration/routing, instance B (MaxOutstanding=2) for backpressure.
module tb_bank_arb_resp_demux_varlat;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]         a_req, a_gnt_o, a_vld_o;
  logic [N-1:0][DW-1:0] a_data;
  logic [DW-1:0]        a_data_o;
  logic [RW-1:0]        a_rdata_i, a_rdata_o;
  logic                 a_req_o, a_gnt_i, a_vld_i, a_err;

  logic [N-1:0]         b_req, b_gnt_o, b_vld_o;
  logic [N-1:0][DW-1:0] b_data;
  logic [DW-1:0]        b_data_o;
  logic [RW-1:0]        b_rdata_i, b_rdata_o;
  logic                 b_req_o, b_gnt_i, b_vld_i, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bank_arb_resp_demux_varlat #(
    .NumIn(N), .ReqDataWidth(DW), .RespDataWidth(RW), .MaxOutstanding(4)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .data_i(a_data), .gnt_o(a_gnt_o),
    .vld_o(a_vld_o), .rdata_o(a_rdata_o), .req_o(a_req_o), .data_o(a_data_o),
    .gnt_i(a_gnt_i), .vld_i(a_vld_i), .rdata_i(a_rdata_i), .err_o(a_err)
  );

  bank_arb_resp_demux_varlat #(
    .NumIn(N), .ReqDataWidth(DW), .RespDataWidth(RW), .MaxOutstanding(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .data_i(b_data), .gnt_o(b_gnt_o),
    .vld_o(b_vld_o), .rdata_o(b_rdata_o), .req_o(b_req_o), .data_o(b_data_o),
    .gnt_i(b_gnt_i), .vld_i(b_vld_i), .rdata_i(b_rdata_i), .err_o(b_err)
  );

  task automatic idle_inputs();
    a_req = 4'h0; a_gnt_i = 1'b0; a_vld_i = 1'b0; a_rdata_i = 32'h0;
    b_req = 4'h0; b_gnt_i = 1'b0; b_vld_i = 1'b0; b_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_req = 4'hF; a_gnt_i = 1'b1; a_vld_i = 1'b1;
    b_req = 4'hF; b_gnt_i = 1'b1; b_vld_i = 1'b1;
    #1;
    n_checks++; if (a_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_o got %b exp 0", a_req_o); end
    n_checks++; if (a_gnt_o !== 4'h0) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", a_gnt_o); end
    n_checks++; if (a_vld_o !== 4'h0) begin n_fail++; $display("FAIL reset_vld got %b exp 0000", a_vld_o); end
    n_checks++; if (b_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_req_o got %b exp 0", b_req_o); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
    n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL reset_b_err got %b exp 0", b_err); end
    n_checks++; if (a_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_req_o got %b exp 0", a_req_o); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_gnt [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
    logic [3:0] exp_vld [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_req = (c < 5) ? 4'hF : 4'h0; a_gnt_i = 1'b1;
      a_vld_i = (c >= 2); a_rdata_i = 32'h50 + 32'(c);
      #1;
      n_checks++; if (a_gnt_o !== exp_gnt[c]) begin n_fail++; $display("FAIL contention_gnt c=%0d got %b exp %b", c, a_gnt_o, exp_gnt[c]); end
      n_checks++; if (a_vld_o !== exp_vld[c]) begin n_fail++; $display("FAIL contention_vld c=%0d got %b exp %b", c, a_vld_o, exp_vld[c]); end
      n_checks++; if (a_rdata_o !== 32'h50 + 32'(c)) begin n_fail++; $display("FAIL contention_rdata c=%0d got %h exp %h", c, a_rdata_o, 32'h50 + 32'(c)); end
      if (c < 5) begin
        n_checks++; if (a_data_o !== 32'h1000 + 32'(exp_idx[c])) begin n_fail++; $display("FAIL contention_data c=%0d got %h exp %h", c, a_data_o, 32'h1000 + 32'(exp_idx[c])); end
      end
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL contention_err got %b exp 0", a_err); end
  endtask

  task automatic test_backpressure();
    logic       t_req  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       t_vld  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       e_reqo [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] e_gnt  [8] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    logic [3:0] e_vld  [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b_req = {3'b000, t_req[c]}; b_gnt_i = 1'b1; b_vld_i = t_vld[c]; b_rdata_i = 32'h77;
      #1;
      n_checks++; if (b_req_o !== e_reqo[c]) begin n_fail++; $display("FAIL backpressure_req_o c=%0d got %b exp %b", c, b_req_o, e_reqo[c]); end
      n_checks++; if (b_gnt_o !== e_gnt[c]) begin n_fail++; $display("FAIL backpressure_gnt c=%0d got %b exp %b", c, b_gnt_o, e_gnt[c]); end
      n_checks++; if (b_vld_o !== e_vld[c]) begin n_fail++; $display("FAIL backpressure_vld c=%0d got %b exp %b", c, b_vld_o, e_vld[c]); end
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL backpressure_err got %b exp 0", b_err); end
  endtask

  task automatic test_var_latency();
    logic [3:0]  t_req [8] = '{4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic        t_vld [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_rd  [8] = '{32'h0, 32'h0, 32'h0, 32'hA, 32'h0, 32'h0, 32'hB, 32'h0};
    logic [3:0]  e_gnt [8] = '{4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  e_vld [8] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1, 4'h0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_req = t_req[c]; a_gnt_i = 1'b1; a_vld_i = t_vld[c]; a_rdata_i = t_rd[c];
      #1;
      n_checks++; if (a_gnt_o !== e_gnt[c]) begin n_fail++; $display("FAIL varlat_gnt c=%0d got %b exp %b", c, a_gnt_o, e_gnt[c]); end
      n_checks++; if (a_vld_o !== e_vld[c]) begin n_fail++; $display("FAIL varlat_vld c=%0d got %b exp %b", c, a_vld_o, e_vld[c]); end
      if (t_vld[c]) begin
        n_checks++; if (a_rdata_o !== t_rd[c]) begin n_fail++; $display("FAIL varlat_rdata c=%0d got %h exp %h", c, a_rdata_o, t_rd[c]); end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [3:0]  t_req [4] = '{4'h2, 4'h8, 4'h0, 4'h0};
    logic        t_vld [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_rd  [4] = '{32'h0, 32'hC1, 32'hC2, 32'h0};
    logic [3:0]  e_gnt [4] = '{4'h2, 4'h8, 4'h0, 4'h0};
    logic [3:0]  e_vld [4] = '{4'h0, 4'h2, 4'h8, 4'h0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_req = t_req[c]; a_gnt_i = 1'b1; a_vld_i = t_vld[c]; a_rdata_i = t_rd[c];
      #1;
      n_checks++; if (a_gnt_o !== e_gnt[c]) begin n_fail++; $display("FAIL pushpop_gnt c=%0d got %b exp %b", c, a_gnt_o, e_gnt[c]); end
      n_checks++; if (a_vld_o !== e_vld[c]) begin n_fail++; $display("FAIL pushpop_vld c=%0d got %b exp %b", c, a_vld_o, e_vld[c]); end
    end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL pushpop_err got %b exp 0", a_err); end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    idle_inputs(); a_vld_i = 1'b1; a_rdata_i = 32'hDEAD;
    #1;
    n_checks++; if (a_vld_o !== 4'h0) begin n_fail++; $display("FAIL spurious_vld got %b exp 0000", a_vld_o); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL spurious_err_early got %b exp 0", a_err); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL spurious_err_sticky c=%0d got %b exp 1", c, a_err); end
    end
  endtask

  task automatic test_reset_midflight();
    logic       t_rst [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] t_req [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    logic       t_vld [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] e_gnt [8] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_vld [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    logic       e_err [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rst = t_rst[c]; a_req = t_req[c]; a_gnt_i = 1'b1; a_vld_i = t_vld[c]; a_rdata_i = 32'hD;
      #1;
      n_checks++; if (a_gnt_o !== e_gnt[c]) begin n_fail++; $display("FAIL rstmid_gnt c=%0d got %b exp %b", c, a_gnt_o, e_gnt[c]); end
      n_checks++; if (a_vld_o !== e_vld[c]) begin n_fail++; $display("FAIL rstmid_vld c=%0d got %b exp %b", c, a_vld_o, e_vld[c]); end
      n_checks++; if (a_err !== e_err[c]) begin n_fail++; $display("FAIL rstmid_err c=%0d got %b exp %b", c, a_err, e_err[c]); end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < N; k++) begin
      a_data[k] = 32'h1000 + 32'(k);
      b_data[k] = 32'h2000 + 32'(k);
    end
    test_reset();
    test_contention();
    test_backpressure();
    test_var_latency();
    test_push_pop();
    test_spurious();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
